// File: rtl/recon_watchdog_pkg.sv
// ----------------------------------------------------------------------------
// recon_watchdog_pkg
// Shared constants for the recon_watchdog Avalon-MM watchdog:
//   - register word offsets
//   - CTRL / STATUS bit positions
//   - FSM state encoding (also visible in STATUS[5:4])
//   - default kick key
// ----------------------------------------------------------------------------
package recon_watchdog_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_TIMEOUT = 3'd1;
    localparam logic [2:0] ADDR_WARN    = 3'd2;
    localparam logic [2:0] ADDR_KICK    = 3'd3;
    localparam logic [2:0] ADDR_COUNT   = 3'd4;
    localparam logic [2:0] ADDR_STATUS  = 3'd5;

    // CTRL bits
    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_IRQ_ENA = 1;
    localparam int unsigned CTRL_LOCK    = 2;

    // STATUS bits
    localparam int unsigned STAT_WARN    = 0;
    localparam int unsigned STAT_EXPIRED = 1;
    localparam int unsigned STAT_BAD_KEY = 2;

    localparam logic [31:0] KICK_KEY_DEFAULT = 32'h5A5A_A5A5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StWarn   = 2'd2,
        StExpire = 2'd3
    } wdt_state_e;

endpackage

// File: rtl/recon_watchdog.sv
// ----------------------------------------------------------------------------
// recon_watchdog
// Avalon-MM slave watchdog clocked by the system clock and timed by the
// system timer's millisec_tick. Software arms it with a millisecond timeout
// and must write the kick key before expiry. A warning interrupt is raised
// when the remaining count drops to WARN; on expiry a fixed-length reset
// request pulse is driven to the reset controller.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   address        Avalon word address (3 bits)
//   chipselect     Avalon select
//   write / read   Avalon strobes
//   writedata      Avalon write data (32 bits)
//   readdata       Avalon read data, registered, 1-cycle latency
//   millisec_tick  one-cycle pulse per millisecond
//   irq            level warning interrupt (irq_ena & warn_flag, registered)
//   wdt_reset_req  reset request pulse, RST_PULSE_CYCLES cycles wide
// ----------------------------------------------------------------------------
module recon_watchdog
    import recon_watchdog_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_DEFAULT  = 32'd1000,
    parameter logic [31:0] WARN_DEFAULT     = 32'd100,
    parameter logic [31:0] KICK_KEY         = KICK_KEY_DEFAULT,
    parameter int unsigned RST_PULSE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        millisec_tick,
    output logic        irq,
    output logic        wdt_reset_req
);

    localparam logic [7:0] PULSE_LAST = 8'(RST_PULSE_CYCLES - 1);

    // Configuration registers
    logic        r_enable;
    logic        r_irq_ena;
    logic        r_lock;
    logic [31:0] r_timeout;
    logic [31:0] r_warn;

    // Counter, FSM and status
    wdt_state_e  r_state;
    logic [31:0] r_count;
    logic [7:0]  r_pulse_cnt;
    logic        r_warn_flag;
    logic        r_expired_flag;
    logic        r_bad_key;
    logic        r_irq;
    logic        r_reset_req;
    logic [31:0] r_readdata;

    logic        w_wr;
    logic        w_rd;
    logic        w_cfg_wr;
    logic        w_status_wr;
    logic        w_kick_wr;
    logic        w_kick_ok;
    logic        w_kick_bad;
    logic [31:0] w_count_dec;
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    assign w_wr        = chipselect & write;
    assign w_rd        = chipselect & read;
    assign w_cfg_wr    = w_wr & ~r_lock;
    assign w_status_wr = w_wr && (address == ADDR_STATUS);
    assign w_kick_wr   = w_wr && (address == ADDR_KICK);
    assign w_kick_ok   = w_kick_wr && (writedata == KICK_KEY);
    assign w_kick_bad  = w_kick_wr && (writedata != KICK_KEY);
    assign w_count_dec = r_count - 32'd1;

    assign w_status = {26'd0, r_state, 1'b0, r_bad_key, r_expired_flag, r_warn_flag};

    // ------------------------------------------------------------------
    // Configuration registers; frozen once lock is set until reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable  <= 1'b0;
            r_irq_ena <= 1'b0;
            r_lock    <= 1'b0;
            r_timeout <= TIMEOUT_DEFAULT;
            r_warn    <= WARN_DEFAULT;
        end else if (w_cfg_wr) begin
            if (address == ADDR_CTRL) begin
                r_enable  <= writedata[CTRL_ENABLE];
                r_irq_ena <= writedata[CTRL_IRQ_ENA];
                r_lock    <= writedata[CTRL_LOCK];
            end
            if (address == ADDR_TIMEOUT) begin
                r_timeout <= writedata;
            end
            if (address == ADDR_WARN) begin
                r_warn <= writedata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog FSM, counter, status flags and reset-request pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= StIdle;
            r_count        <= TIMEOUT_DEFAULT;
            r_pulse_cnt    <= 8'd0;
            r_warn_flag    <= 1'b0;
            r_expired_flag <= 1'b0;
            r_bad_key      <= 1'b0;
            r_reset_req    <= 1'b0;
        end else begin
            // W1C first: any flag set later in this block overrides the clear
            if (w_status_wr) begin
                if (writedata[STAT_WARN])    r_warn_flag    <= 1'b0;
                if (writedata[STAT_EXPIRED]) r_expired_flag <= 1'b0;
                if (writedata[STAT_BAD_KEY]) r_bad_key      <= 1'b0;
            end

            unique case (r_state)
                StIdle: begin
                    if (r_enable) begin
                        r_state <= StRun;
                        r_count <= r_timeout;
                    end
                end

                StRun, StWarn: begin
                    if (w_kick_bad) begin
                        r_bad_key <= 1'b1;
                    end
                    if (!r_enable) begin
                        r_state <= StIdle;
                    end else if (w_kick_ok) begin
                        // Kick beats a same-cycle tick: reload, no decrement
                        r_state <= StRun;
                        r_count <= r_timeout;
                    end else if (w_kick_bad && r_lock) begin
                        r_state        <= StExpire;
                        r_expired_flag <= 1'b1;
                        r_pulse_cnt    <= 8'd0;
                        r_reset_req    <= 1'b1;
                    end else if (millisec_tick) begin
                        if (r_count == 32'd0) begin
                            r_state        <= StExpire;
                            r_expired_flag <= 1'b1;
                            r_pulse_cnt    <= 8'd0;
                            r_reset_req    <= 1'b1;
                        end else begin
                            r_count <= w_count_dec;
                            if ((r_state == StRun) && (w_count_dec <= r_warn)) begin
                                r_state     <= StWarn;
                                r_warn_flag <= 1'b1;
                            end
                        end
                    end
                end

                StExpire: begin
                    // Pulse always runs to completion; enable only picks the exit
                    if (r_pulse_cnt == PULSE_LAST) begin
                        r_reset_req <= 1'b0;
                        r_pulse_cnt <= 8'd0;
                        if (r_enable) begin
                            r_state <= StRun;
                            r_count <= r_timeout;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Interrupt and read data
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = 32'd0;
        case (address)
            ADDR_CTRL:    w_rdata = {29'd0, r_lock, r_irq_ena, r_enable};
            ADDR_TIMEOUT: w_rdata = r_timeout;
            ADDR_WARN:    w_rdata = r_warn;
            ADDR_COUNT:   w_rdata = r_count;
            ADDR_STATUS:  w_rdata = w_status;
            default:      w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq      <= 1'b0;
            r_readdata <= 32'd0;
        end else begin
            r_irq <= r_irq_ena & r_warn_flag;
            if (w_rd) begin
                r_readdata <= w_rdata;
            end
        end
    end

    assign readdata      = r_readdata;
    assign irq           = r_irq;
    assign wdt_reset_req = r_reset_req;

endmodule

// File: tb/tb_recon_watchdog.sv
// ----------------------------------------------------------------------------
// tb_recon_watchdog
// Self-checking bench for recon_watchdog. Each scenario task drives the bus
// and tick, pushes expected read values onto a scoreboard queue and pops
// them when the registered read data comes back.
// ----------------------------------------------------------------------------
module tb_recon_watchdog;
    import recon_watchdog_pkg::*;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        millisec_tick;
    logic        irq;
    logic        wdt_reset_req;

    int n_chk;
    int n_pass;
    int req_cycles;
    logic [31:0] exp_q[$];

    recon_watchdog dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .chipselect    (chipselect),
        .write         (write),
        .read          (read),
        .writedata     (writedata),
        .readdata      (readdata),
        .millisec_tick (millisec_tick),
        .irq           (irq),
        .wdt_reset_req (wdt_reset_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Total cycles with the reset request asserted, for "no expiry" checks
    initial req_cycles = 0;
    always @(posedge clk) if (wdt_reset_req === 1'b1) req_cycles <= req_cycles + 1;

    // ---------------- bus helpers (stimulus only) ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = 3'd0; writedata = 32'd0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        cycle();
        idle_bus();
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        cycle();
        idle_bus();
        d = readdata;
    endtask

    task automatic tick();
        millisec_tick = 1'b1;
        cycle();
        millisec_tick = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        millisec_tick = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd, ex;
        idle_bus();
        millisec_tick = 1'b0;
        reset_n = 1'b0;
        #3;
        n_chk++;
        if ({readdata, irq, wdt_reset_req} !== 34'd0)
            $display("FAIL reset_outputs got rd=%h irq=%b req=%b want 0", readdata, irq,
                     wdt_reset_req);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1000);
        exp_q.push_back(32'd100);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1000);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        for (int a = 0; a < 7; a++) begin
            bus_read(3'(a), rd);
            ex = exp_q.pop_front();
            n_chk++;
            if (rd !== ex) $display("FAIL reset_reg%0d got %h want %h", a, rd, ex);
            else n_pass++;
        end
    endtask

    task automatic test_expiry();
        logic [31:0] rd, ex;
        int hi;
        do_reset();
        bus_write(ADDR_TIMEOUT, 32'd5);
        bus_write(ADDR_WARN, 32'd2);
        bus_write(ADDR_CTRL, 32'd3);
        cycle();
        for (int t = 1; t <= 5; t++) begin
            tick();
            repeat (9) cycle();
            if (t == 2) begin
                n_chk++;
                if (irq !== 1'b0) $display("FAIL exp_irq_early got %b want 0", irq);
                else n_pass++;
            end
            if (t == 3) begin
                n_chk++;
                if (irq !== 1'b1) $display("FAIL exp_irq got %b want 1", irq);
                else n_pass++;
                exp_q.push_back(32'd2);
                bus_read(ADDR_COUNT, rd);
                ex = exp_q.pop_front();
                n_chk++;
                if (rd !== ex) $display("FAIL exp_count got %h want %h", rd, ex);
                else n_pass++;
                exp_q.push_back(32'h21);
                bus_read(ADDR_STATUS, rd);
                ex = exp_q.pop_front();
                n_chk++;
                if (rd !== ex) $display("FAIL exp_status_warn got %h want %h", rd, ex);
                else n_pass++;
            end
        end
        tick();
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (wdt_reset_req === 1'b1) hi++;
            cycle();
        end
        n_chk++;
        if (hi != 16) $display("FAIL exp_pulse_len got %0d want 16", hi);
        else n_pass++;
        exp_q.push_back(32'h13);
        bus_read(ADDR_STATUS, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL exp_status_expired got %h want %h", rd, ex);
        else n_pass++;
    endtask

    task automatic test_kick();
        logic [31:0] rd, ex;
        int r0;
        do_reset();
        r0 = req_cycles;
        bus_write(ADDR_TIMEOUT, 32'd5);
        bus_write(ADDR_WARN, 32'd2);
        bus_write(ADDR_CTRL, 32'd3);
        cycle();
        for (int t = 1; t <= 4; t++) begin
            tick();
            repeat (9) cycle();
        end
        bus_write(ADDR_KICK, KEY);
        exp_q.push_back(32'd5);
        bus_read(ADDR_COUNT, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL kick_count got %h want %h", rd, ex);
        else n_pass++;
        exp_q.push_back(32'h11);
        bus_read(ADDR_STATUS, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL kick_status got %h want %h", rd, ex);
        else n_pass++;
        n_chk++;
        if (irq !== 1'b1) $display("FAIL kick_irq_held got %b want 1", irq);
        else n_pass++;
        bus_write(ADDR_STATUS, 32'd1);
        cycle();
        n_chk++;
        if (irq !== 1'b0) $display("FAIL kick_irq_cleared got %b want 0", irq);
        else n_pass++;
        n_chk++;
        if (req_cycles != r0) $display("FAIL kick_no_req got %0d want %0d", req_cycles, r0);
        else n_pass++;
    endtask

    task automatic test_lock_bad_key();
        logic [31:0] rd, ex;
        do_reset();
        bus_write(ADDR_TIMEOUT, 32'd50);
        bus_write(ADDR_CTRL, 32'd7);
        cycle();
        bus_write(ADDR_KICK, 32'h1234_5678);
        n_chk++;
        if (wdt_reset_req !== 1'b1) $display("FAIL lock_expire got %b want 1", wdt_reset_req);
        else n_pass++;
        exp_q.push_back(32'h36);
        bus_read(ADDR_STATUS, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL lock_status got %h want %h", rd, ex);
        else n_pass++;
        bus_write(ADDR_TIMEOUT, 32'd9);
        exp_q.push_back(32'd50);
        bus_read(ADDR_TIMEOUT, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL lock_timeout got %h want %h", rd, ex);
        else n_pass++;
    endtask

    task automatic test_kick_and_tick();
        logic [31:0] rd, ex;
        int r0;
        do_reset();
        r0 = req_cycles;
        bus_write(ADDR_TIMEOUT, 32'd3);
        bus_write(ADDR_WARN, 32'd0);
        bus_write(ADDR_CTRL, 32'd1);
        cycle();
        tick();
        tick();
        exp_q.push_back(32'd1);
        bus_read(ADDR_COUNT, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL kt_count_pre got %h want %h", rd, ex);
        else n_pass++;
        chipselect = 1'b1; write = 1'b1; address = ADDR_KICK; writedata = KEY;
        millisec_tick = 1'b1;
        cycle();
        idle_bus();
        millisec_tick = 1'b0;
        exp_q.push_back(32'd3);
        bus_read(ADDR_COUNT, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL kt_count got %h want %h", rd, ex);
        else n_pass++;
        exp_q.push_back(32'h10);
        bus_read(ADDR_STATUS, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL kt_status got %h want %h", rd, ex);
        else n_pass++;
        n_chk++;
        if (req_cycles != r0) $display("FAIL kt_no_req got %0d want %0d", req_cycles, r0);
        else n_pass++;
    endtask

    task automatic test_zero_timeout();
        logic [31:0] rd, ex;
        int hi;
        do_reset();
        bus_write(ADDR_TIMEOUT, 32'd0);
        bus_write(ADDR_CTRL, 32'd1);
        cycle();
        tick();
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (wdt_reset_req === 1'b1) hi++;
            if (i == 2) begin
                chipselect = 1'b1; write = 1'b1; address = ADDR_CTRL; writedata = 32'd0;
            end else begin
                idle_bus();
            end
            cycle();
        end
        idle_bus();
        n_chk++;
        if (hi != 16) $display("FAIL zero_pulse_len got %0d want 16", hi);
        else n_pass++;
        exp_q.push_back(32'h02);
        bus_read(ADDR_STATUS, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL zero_status got %h want %h", rd, ex);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [31:0] rd, ex;
        do_reset();
        bus_write(ADDR_TIMEOUT, 32'd2);
        bus_write(ADDR_WARN, 32'd1);
        bus_write(ADDR_CTRL, 32'd3);
        cycle();
        tick();
        cycle();
        n_chk++;
        if (irq !== 1'b1) $display("FAIL ar_irq got %b want 1", irq);
        else n_pass++;
        tick();
        tick();
        bus_read(ADDR_TIMEOUT, rd);
        n_chk++;
        if ({rd, wdt_reset_req} !== {32'd2, 1'b1})
            $display("FAIL ar_mid_pulse got rd=%h req=%b want rd=2 req=1", rd, wdt_reset_req);
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({readdata, irq, wdt_reset_req} !== 34'd0)
            $display("FAIL ar_async got rd=%h irq=%b req=%b want 0", readdata, irq,
                     wdt_reset_req);
        else n_pass++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle();
        exp_q.push_back(32'd0);
        bus_read(ADDR_CTRL, rd);
        ex = exp_q.pop_front();
        n_chk++;
        if (rd !== ex) $display("FAIL ar_ctrl got %h want %h", rd, ex);
        else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_expiry();
        test_kick();
        test_lock_bad_key();
        test_kick_and_tick();
        test_zero_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout got running want finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/recon_watchdog.md
Name: recon_watchdog

Overview:
Avalon-MM slave watchdog that sits directly downstream of the system timer and consumes its millisec_tick pulse as its time base. Software arms it with a millisecond timeout and must write a kick key before expiry. On approach to expiry it raises a warning interrupt. On expiry it drives a fixed-length reset-request pulse to the system reset controller.

Parameters:
TIMEOUT_DEFAULT, 1000, reset value of TIMEOUT register (ms)
WARN_DEFAULT, 100, reset value of WARN register (ms remaining at which warning fires)
KICK_KEY, 32'h5A5AA5A5, value that must be written to KICK to reload
RST_PULSE_CYCLES, 16, width of wdt_reset_req pulse in clk cycles (>=1)

Ports:
clk  in  1  system clock, same domain as timer
reset_n  in  1  asynchronous active-low reset
address  in  3  Avalon word address
chipselect  in  1  Avalon select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
millisec_tick  in  1  one-cycle pulse per ms from timer
irq  out  1  level warning interrupt
wdt_reset_req  out  1  reset request pulse

Behaviour:
- Clocking and reset: one clock (clk); reset_n asynchronous, active-low. On reset: state IDLE, count=TIMEOUT_DEFAULT, CTRL=0, STATUS flags=0, readdata=0, irq=0, wdt_reset_req=0.
- Register map (word address):
  - 0 CTRL: bit0 enable, bit1 irq_ena, bit2 lock.
  - 1 TIMEOUT[31:0].
  - 2 WARN[31:0].
  - 3 KICK: write-only; reads return 0.
  - 4 COUNT: read-only, remaining ms.
  - 5 STATUS: bit0 warn_flag (W1C), bit1 expired_flag (W1C), bit2 bad_key (W1C), bits[5:4] state.
  - 6, 7: read as 0; writes ignored.
- Read path: readdata updates on the clk edge where chipselect&&read, so latency is 1 cycle. Otherwise readdata holds its last value.
- Lock: once lock=1, writes to CTRL, TIMEOUT and WARN are ignored until reset_n. W1C writes to STATUS still work.
- FSM states: IDLE=0, RUN=1, WARN=2, EXPIRE=3.
  - IDLE: enter RUN when enable=1, loading count=TIMEOUT.
  - RUN: on millisec_tick, if count==0, go to EXPIRE. Otherwise count<=count-1. If the new count is <= WARN, go to WARN and set warn_flag.
  - WARN: on tick, decrement; expire when count==0 at the tick.
  - EXPIRE: set expired_flag. Assert wdt_reset_req for exactly RST_PULSE_CYCLES cycles (internal 8-bit pulse counter). Then, if enable=1, go to RUN with count=TIMEOUT; otherwise go to IDLE.
- Kick: a write of KICK_KEY to address 3 in RUN or WARN sets count=TIMEOUT and state=RUN. It does not clear warn_flag.
  - A wrong key sets bad_key.
  - If lock=1, a wrong key also forces EXPIRE on the next cycle.
  - Kicks in IDLE or EXPIRE are ignored, including the wrong-key case.
- Simultaneous events:
  - Kick and tick in the same cycle: the kick wins (reload, no decrement).
  - W1C and flag set in the same cycle: set wins.
  - Clearing enable in RUN/WARN: IDLE next cycle, count holds.
  - Clearing enable in EXPIRE: the pulse completes, then IDLE.
- irq = irq_ena & warn_flag, registered.
- Boundaries:
  - TIMEOUT=0: expires on the first tick after enable.
  - WARN>=TIMEOUT: WARN is entered on the first tick.
  - count never wraps below 0.

Decomposition:
- Shared header/package recon_watchdog_pkg holds:
  - register offsets;
  - CTRL/STATUS bit indices;
  - the 2-bit state encoding;
  - the default KICK_KEY.
- Single module; no sub-module is needed. The counter and FSM are small enough to stay inline.

Test Plan:
1. Reset, write TIMEOUT=5, WARN=2, CTRL=3, no kicks, 1 tick per 10 cycles -> warn_flag and irq after the 3rd tick, count=2. wdt_reset_req high exactly 16 cycles after the 6th tick, expired_flag=1.
2. Same setup, write KICK=32'h5A5AA5A5 after the 4th tick -> COUNT reads 5, state RUN, irq stays 1 until STATUS is written with 1. No reset request.
3. Lock set (CTRL=7), KICK write of 32'h12345678 -> bad_key=1 and EXPIRE on the next cycle. A subsequent TIMEOUT write is ignored (reads back the old value).
4. Kick and millisec_tick in the same cycle with count=1 -> COUNT=TIMEOUT, no expiry.
5. TIMEOUT=0, enable -> expire on the first tick. Clear enable during the pulse -> full 16-cycle pulse, then state IDLE.
6. Assert reset_n low mid-pulse -> wdt_reset_req, irq and readdata are 0 immediately (asynchronously). CTRL reads 0 after release.
